// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus, driving registered
// complementary EN/EN_BAR pairs with a break-before-make turnaround gap.
module tbuf_bus_arbiter #(
   parameter int N        = 4,
   parameter int TURN     = 1,
   parameter int MAX_HOLD = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [N-1:0]         REQ,
   output logic [N-1:0]         GNT,
   output logic [N-1:0]         EN,
   output logic [N-1:0]         EN_BAR,
   output logic [$clog2(N)-1:0] OWNER,
   output logic                 BUSY
);

   localparam int OW = $clog2(N);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_TURN
   } state_t;

   state_t        r_state;
   logic [N-1:0]  r_gnt;
   logic [N-1:0]  r_en;
   logic [N-1:0]  r_enBar;
   logic [OW-1:0] r_owner;
   logic          r_busy;
   logic [OW-1:0] r_ptr;
   logic [7:0]    r_hold;
   logic [2:0]    r_turn;

   logic [OW-1:0] w_pick;
   logic          w_found;
   logic [N-1:0]  w_pickOneHot;
   logic          w_anyReq;
   logic          w_ownerReq;
   logic          w_othersReq;
   logic [7:0]    w_holdNext;
   logic [OW-1:0] w_nextPtr;
   logic          w_release;

   // Round-robin pick: lowest requester at or above the pointer, else wrap to the lowest overall.
   always_comb begin
      w_pick  = '0;
      w_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!w_found && REQ[i] && (OW'(i) >= r_ptr)) begin
            w_pick  = OW'(i);
            w_found = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!w_found && REQ[i]) begin
            w_pick  = OW'(i);
            w_found = 1'b1;
         end
      end
      w_pickOneHot = '0;
      for (int i = 0; i < N; i++) begin
         w_pickOneHot[i] = (w_pick == OW'(i));
      end
   end

   // The hold counter reaches MAX_HOLD at the edge that completes the owner's MAX_HOLD-th cycle.
   assign w_anyReq    = |REQ;
   assign w_ownerReq  = |(REQ & r_gnt);
   assign w_othersReq = |(REQ & ~r_gnt);
   assign w_holdNext  = (r_hold >= 8'(MAX_HOLD)) ? r_hold : r_hold + 8'd1;
   assign w_nextPtr   = (r_owner == OW'(N - 1)) ? '0 : r_owner + 1'b1;
   assign w_release   = !w_ownerReq || ((w_holdNext == 8'(MAX_HOLD)) && w_othersReq);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_en    <= '0;
         r_enBar <= '1;
         r_owner <= '0;
         r_busy  <= 1'b0;
         r_ptr   <= '0;
         r_hold  <= '0;
         r_turn  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_anyReq) begin
                  r_gnt   <= w_pickOneHot;
                  r_en    <= w_pickOneHot;
                  r_enBar <= ~w_pickOneHot;
                  r_owner <= w_pick;
                  r_hold  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (w_release) begin
                  r_gnt   <= '0;
                  r_en    <= '0;
                  r_enBar <= '1;
                  r_ptr   <= w_nextPtr;
                  r_turn  <= '0;
                  r_state <= ST_TURN;
               end else begin
                  r_hold <= w_holdNext;
               end
            end
            ST_TURN: begin
               if (r_turn == 3'(TURN - 1)) begin
                  if (w_anyReq) begin
                     r_gnt   <= w_pickOneHot;
                     r_en    <= w_pickOneHot;
                     r_enBar <= ~w_pickOneHot;
                     r_owner <= w_pick;
                     r_hold  <= '0;
                     r_state <= ST_DRIVE;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_turn <= r_turn + 3'd1;
               end
            end
            default: begin
               r_gnt   <= '0;
               r_en    <= '0;
               r_enBar <= '1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign GNT    = r_gnt;
   assign EN     = r_en;
   assign EN_BAR = r_enBar;
   assign OWNER  = r_owner;
   assign BUSY   = r_busy;

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Directed and randomized checks of tbuf_bus_arbiter: one instance with a
// 1-cycle turnaround, one with a 3-cycle turnaround, sharing clock and reset.
module tb_tbuf_bus_arbiter;

   logic       clock;
   logic       reset;
   logic [3:0] reqA, gntA, enA, enBarA;
   logic [1:0] ownerA;
   logic       busyA;
   logic [3:0] reqB, gntB, enB, enBarB;
   logic [1:0] ownerB;
   logic       busyB;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic       sel;
      logic [3:0] gnt;
      logic [1:0] owner;
      logic       busy;
   } exp_t;

   exp_t  expQ[$];
   string tagQ[$];

   tbuf_bus_arbiter #(.N(4), .TURN(1), .MAX_HOLD(8)) dutA (
      .CLK(clock), .RST(reset), .REQ(reqA), .GNT(gntA), .EN(enA),
      .EN_BAR(enBarA), .OWNER(ownerA), .BUSY(busyA)
   );

   tbuf_bus_arbiter #(.N(4), .TURN(3), .MAX_HOLD(8)) dutB (
      .CLK(clock), .RST(reset), .REQ(reqB), .GNT(gntB), .EN(enB),
      .EN_BAR(enBarB), .OWNER(ownerB), .BUSY(busyB)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Pops one expected entry and compares every output of the selected instance.
   task automatic checkOutput();
      exp_t       e;
      string      tag;
      logic [3:0] g, en, enb;
      logic [1:0] o;
      logic       b;
      if (expQ.size() == 0) begin
         checks++;
         failures++;
         $error("[TB] FAIL scoreboard_empty actual=0 entries required=1 entry");
         return;
      end
      e   = expQ.pop_front();
      tag = tagQ.pop_front();
      if (e.sel) begin
         g = gntB; en = enB; enb = enBarB; o = ownerB; b = busyB;
      end else begin
         g = gntA; en = enA; enb = enBarA; o = ownerA; b = busyA;
      end
      checks++;
      assert (g === e.gnt) else begin
         failures++;
         $error("[TB] FAIL %s GNT actual=%b required=%b", tag, g, e.gnt);
      end
      checks++;
      assert (en === e.gnt) else begin
         failures++;
         $error("[TB] FAIL %s EN actual=%b required=%b", tag, en, e.gnt);
      end
      checks++;
      assert (enb === ~e.gnt) else begin
         failures++;
         $error("[TB] FAIL %s EN_BAR actual=%b required=%b", tag, enb, ~e.gnt);
      end
      checks++;
      assert (o === e.owner) else begin
         failures++;
         $error("[TB] FAIL %s OWNER actual=%0d required=%0d", tag, o, e.owner);
      end
      checks++;
      assert (b === e.busy) else begin
         failures++;
         $error("[TB] FAIL %s BUSY actual=%b required=%b", tag, b, e.busy);
      end
   endtask

   task automatic pushExpect(input logic sel, input logic [3:0] expGnt,
                             input logic [1:0] expOwner, input logic expBusy,
                             input string tag);
      exp_t e;
      e.sel   = sel;
      e.gnt   = expGnt;
      e.owner = expOwner;
      e.busy  = expBusy;
      expQ.push_back(e);
      tagQ.push_back(tag);
   endtask

   // Drives REQ of one instance before the next edge and checks it just after.
   task automatic applyStimulus(input logic sel, input logic [3:0] req,
                                input logic [3:0] expGnt, input logic [1:0] expOwner,
                                input logic expBusy, input string tag);
      if (sel) reqB = req;
      else     reqA = req;
      pushExpect(sel, expGnt, expOwner, expBusy, tag);
      @(posedge clock);
      #1;
      checkOutput();
   endtask

   task automatic expectNow(input logic sel, input logic [3:0] expGnt,
                            input logic [1:0] expOwner, input logic expBusy,
                            input string tag);
      pushExpect(sel, expGnt, expOwner, expBusy, tag);
      checkOutput();
   endtask

   int         offRun;
   logic [3:0] lastEn;
   logic [3:0] rnd;

   initial begin
      reqA  = '0;
      reqB  = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      expectNow(1'b0, 4'b0000, 2'd0, 1'b0, "reset_a");
      expectNow(1'b1, 4'b0000, 2'd0, 1'b0, "reset_b");
      @(posedge clock);
      #1 reset = 1'b0;

      $display("[TB] single requester");
      applyStimulus(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, "single_grant");
      for (int c = 1; c < 5; c++)
         applyStimulus(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, $sformatf("single_hold%0d", c));
      applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, "single_release");
      applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "single_idle");

      $display("[TB] uncontended hold then late contender");
      for (int c = 0; c < 20; c++)
         applyStimulus(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, $sformatf("uncontended%0d", c));
      applyStimulus(1'b0, 4'b0110, 4'b0000, 2'd2, 1'b1, "saturated_release");
      applyStimulus(1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1, "rr_next_owner1");
      applyStimulus(1'b0, 4'b0100, 4'b0000, 2'd1, 1'b1, "owner1_drop");
      applyStimulus(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, "owner2_regrant");

      $display("[TB] asynchronous reset while owner 2 drives");
      #2 reset = 1'b1;
      #1;
      expectNow(1'b0, 4'b0000, 2'd0, 1'b0, "async_reset_a");
      expectNow(1'b1, 4'b0000, 2'd0, 1'b0, "async_reset_b");
      reqA = 4'b0101;
      #1 reset = 1'b0;
      applyStimulus(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, "post_reset_ptr0");

      $display("[TB] full contention");
      for (int c = 1; c < 8; c++)
         applyStimulus(1'b0, 4'hF, 4'b0001, 2'd0, 1'b1, $sformatf("contend_o0_c%0d", c));
      for (int o = 1; o <= 4; o++) begin
         applyStimulus(1'b0, 4'hF, 4'b0000, 2'((o - 1) % 4), 1'b1, $sformatf("contend_gap%0d", o));
         for (int c = 0; c < 8; c++)
            applyStimulus(1'b0, 4'hF, 4'b0001 << (o % 4), 2'(o % 4), 1'b1,
                          $sformatf("contend_o%0d_c%0d", o % 4, c));
      end
      applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, "contend_release");
      applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "contend_idle");

      $display("[TB] three-cycle turnaround");
      applyStimulus(1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1, "turn_grant0");
      applyStimulus(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b1, "turn_gap1");
      applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, "turn_gap2");
      applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, "turn_gap3");
      applyStimulus(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, "turn_grant2");
      applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b1, "turn_drop_gap1");
      applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b1, "turn_drop_gap2");
      applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b1, "turn_drop_gap3");
      applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, "turn_idle");

      $display("[TB] random requests with invariant checks");
      offRun = 0;
      lastEn = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         rnd = reqA;
         for (int b = 0; b < 4; b++)
            if ($urandom_range(7) == 0) rnd[b] = ~rnd[b];
         reqA = rnd;
         @(posedge clock);
         #1;
         checks++;
         assert ($countones(enA) <= 1) else begin
            failures++;
            $error("[TB] FAIL rand_onehot EN actual=%b required=at most one bit", enA);
         end
         checks++;
         assert (enBarA === ~enA) else begin
            failures++;
            $error("[TB] FAIL rand_enbar EN_BAR actual=%b required=%b", enBarA, ~enA);
         end
         checks++;
         assert (gntA === enA) else begin
            failures++;
            $error("[TB] FAIL rand_gnt_en GNT actual=%b required=%b", gntA, enA);
         end
         if (enA == 4'b0000) begin
            offRun++;
         end else begin
            if (lastEn != 4'b0000 && enA != lastEn) begin
               checks++;
               assert (offRun >= 1) else begin
                  failures++;
                  $error("[TB] FAIL rand_gap offcycles actual=%0d required>=%0d", offRun, 1);
               end
            end
            lastEn = enA;
            offRun = 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
